mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's load/store and fetch requests; it is the far end of the request path driven by the control unit.
- Accepts one request at a time, waits a programmable number of cycles, then commits the write or presents the read data, and pulses ready for one cycle.
- Contains the word-organised storage array. The CPU FSM stalls until ready instead of counting fixed wait states.

---
 rtl/mem_responder.sv | 91 +++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, then
// commits the write or presents read data with a one-cycle ready strobe.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;

    logic [31:0]     mem [DEPTH];

    // Upper address bits deliberately ignored: accesses wrap modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    mis_d   = |addr[1:0];
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage is not reset; a reset drops the FSM out of RESP so no write lands.
    always_ff @(posedge clock) begin
        if (state_q == RESP && we_q && !mis_q) mem[idx_q] <= wdata_q;
    end

    assign ready = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign err   = ready && mis_q;
    assign rdata = (ready && !we_q && !mis_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance and one LATENCY=0
// instance, with a reference word model feeding an expected-response queue.
module tb_mem_responder;
    localparam int DEPTH = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req_a, we_a, ready_a, busy_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ready_b, busy_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_a (
        .clock(clock), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .err(err_a));

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_b (
        .clock(clock), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .err(err_b));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];
    logic [31:0] got;
    int          pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (s) begin req_b = r; we_b = w; addr_b = a; wdata_b = d; end
        else   begin req_a = r; we_a = w; addr_a = a; wdata_a = d; end
    endtask

    function automatic logic rdy(input bit s);         return s ? ready_b : ready_a; endfunction
    function automatic logic bsy(input bit s);         return s ? busy_b  : busy_a;  endfunction
    function automatic logic er(input bit s);          return s ? err_b   : err_a;   endfunction
    function automatic logic [31:0] rdt(input bit s);  return s ? rdata_b : rdata_a; endfunction

    // One request held for exactly one sampled cycle; expected response is
    // derived from the word model and queued, then popped on ready.
    task automatic transact(input bit s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd);
        int   lat;
        int   idx;
        bit   mis;
        bit   done;
        exp_t e;
        exp_t e2;
        lat   = s ? 0 : 2;
        idx   = int'((a >> 2) & (DEPTH - 1));
        mis   = (a[1:0] != 2'b00);
        e.err = mis;
        e.rdata = 32'd0;
        if (!w && !mis) e.rdata = s ? mdl_b[idx] : mdl_a[idx];
        sb.push_back(e);
        if (w && !mis) begin
            if (s) mdl_b[idx] = d; else mdl_a[idx] = d;
        end
        rd   = 32'd0;
        done = 1'b0;
        @(negedge clock);
        drive(s, 1'b1, w, a, d);
        for (int k = 1; k <= lat + 8 && !done; k++) begin
            @(negedge clock);
            if (k == 1) drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
            if (k <= lat + 1) chk("busy_window", {31'd0, bsy(s)}, 32'd1);
            if (rdy(s)) begin
                done = 1'b1;
                e2 = sb.pop_front();
                chk("ready_latency", k, lat + 1);
                chk("err", {31'd0, er(s)}, {31'd0, e2.err});
                chk("rdata", rdt(s), e2.rdata);
                rd = rdt(s);
            end
        end
        if (!done) begin
            chk("ready_timeout", {31'd0, done}, 32'd1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        // Request during reset must not be accepted.
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h5555_5555);
        repeat (3) @(negedge clock);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a},  32'd0);
        chk("rst_err",   {31'd0, err_a},   32'd0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        chk("req_in_reset_ignored", {31'd0, busy_a}, 32'd0);

        // Basic write then read, LATENCY=2.
        transact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, got);
        @(negedge clock);
        chk("ready_one_cycle", {31'd0, ready_a}, 32'd0);
        chk("busy_after_resp", {31'd0, busy_a}, 32'd0);
        transact(1'b0, 1'b0, 32'h10, 32'd0, got);
        chk("rd_0x10", got, 32'hDEAD_BEEF);

        // Wrap-around modulo DEPTH words.
        transact(1'b0, 1'b1, 32'h0, 32'h1234_5678, got);
        transact(1'b0, 1'b0, 32'h0, 32'd0, got);
        chk("rd_0x0", got, 32'h1234_5678);
        transact(1'b0, 1'b0, 32'h400, 32'd0, got);
        chk("rd_0x400_wrap", got, 32'h1234_5678);

        // Misaligned write flagged and suppressed; misaligned read gives 0.
        transact(1'b0, 1'b1, 32'h13, 32'hFFFF_FFFF, got);
        transact(1'b0, 1'b0, 32'h10, 32'd0, got);
        chk("rd_after_misaligned", got, 32'hDEAD_BEEF);
        transact(1'b0, 1'b0, 32'h11, 32'd0, got);

        // Request while busy is ignored.
        transact(1'b0, 1'b1, 32'h44, 32'h2222_2222, got);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hAAAA_AAAA);
        mdl_a[16] = 32'hAAAA_AAAA;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) drive(1'b0, 1'b1, 1'b1, 32'h44, 32'hBBBB_BBBB);
            if (ready_a) begin
                pulses++;
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        chk("busy_req_pulses", pulses, 1);
        transact(1'b0, 1'b0, 32'h40, 32'd0, got);
        chk("rd_0x40_first_req", got, 32'hAAAA_AAAA);
        transact(1'b0, 1'b0, 32'h44, 32'd0, got);
        chk("rd_0x44_untouched", got, 32'h2222_2222);

        // Reset during WAIT aborts the pending write.
        transact(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, got);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h0BAD_F00D);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("busy_before_abort", {31'd0, busy_a}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_ready", {31'd0, ready_a}, 32'd0);
        chk("abort_busy",  {31'd0, busy_a},  32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (ready_a) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        transact(1'b0, 1'b0, 32'h20, 32'd0, got);
        chk("rd_0x20_prewrite", got, 32'hCAFE_F00D);

        // LATENCY=0: one-cycle latency, back-to-back at spacing 2.
        transact(1'b1, 1'b1, 32'h8, 32'h0123_4567, got);
        transact(1'b1, 1'b1, 32'hC, 32'h89AB_CDEF, got);
        transact(1'b1, 1'b0, 32'h8, 32'd0, got);
        chk("b2b_rd_0x8", got, 32'h0123_4567);
        transact(1'b1, 1'b0, 32'hC, 32'd0, got);
        chk("b2b_rd_0xC", got, 32'h89AB_CDEF);
        transact(1'b1, 1'b1, 32'h8, 32'h5555_AAAA, got);
        transact(1'b1, 1'b0, 32'h8, 32'd0, got);
        chk("raw_rd_0x8", got, 32'h5555_AAAA);
        @(negedge clock);
        chk("b_idle_after", {31'd0, busy_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
